xbar_collect: RTL and testbench

//  Return path of the PE crossbar: gathers one result batch from all NUM_PES

---
 rtl/xbar_collect.sv | 126 ++++++++++++
 tb/tb_xbar_collect.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_collect.sv
// Return path of the PE crossbar: captures one result batch from all PEs and
// streams its non-empty OUT_BW-lane chunks to the output buffer in ascending order.
module xbar_collect #(
    parameter int DATA_TYPE = 16,
    parameter int NUM_PES   = 64,
    parameter int OUT_BW    = 16,
    parameter int LOG2_PES  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PES*DATA_TYPE-1:0]  i_data_bus,
    input  logic [NUM_PES-1:0]            i_valid_bus,
    input  logic                          i_vld,
    output logic                          o_rdy,
    output logic [OUT_BW*DATA_TYPE-1:0]   o_data,
    output logic [OUT_BW-1:0]             o_lane_vld,
    output logic [LOG2_PES-1:0]           o_chunk,
    output logic                          o_vld,
    input  logic                          i_rdy,
    output logic                          o_last,
    output logic                          o_done
);

    localparam int NUM_CHUNKS = NUM_PES / OUT_BW;
    localparam int CHUNK_W    = OUT_BW * DATA_TYPE;
    localparam logic [LOG2_PES-1:0] LAST_CHUNK = LOG2_PES'(NUM_CHUNKS - 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                         state, state_nxt;
    logic [NUM_PES*DATA_TYPE-1:0]   data_p0;
    logic [NUM_PES-1:0]             slot_vld_p0;
    logic [LOG2_PES-1:0]            ptr, ptr_nxt;
    logic                           done_q, done_nxt;
    logic                           capture;
    logic                           beat;
    logic [OUT_BW-1:0]              mask;
    logic [CHUNK_W-1:0]             chunk_data;
    logic [NUM_CHUNKS-1:0]          chunk_any;
    logic                           later_any;

    // Capture stage: batch registers, chunk pointer and done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ptr         <= '0;
            done_q      <= 1'b0;
            data_p0     <= '0;
            slot_vld_p0 <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            done_q <= done_nxt;
            if (capture) begin
                data_p0     <= i_data_bus;
                slot_vld_p0 <= i_valid_bus;
            end
        end
    end

    // Select the chunk under the pointer and look ahead for any later valid slot
    always_comb begin
        mask       = '0;
        chunk_data = '0;
        chunk_any  = '0;
        later_any  = 1'b0;
        for (int c = 0; c < NUM_CHUNKS; c++) begin
            chunk_any[c] = |slot_vld_p0[c*OUT_BW +: OUT_BW];
            if (LOG2_PES'(c) == ptr) begin
                mask       = slot_vld_p0[c*OUT_BW +: OUT_BW];
                chunk_data = data_p0[c*CHUNK_W +: CHUNK_W];
            end
            if (LOG2_PES'(c) > ptr) begin
                later_any = later_any | chunk_any[c];
            end
        end
    end

    // Drain stage: FSM next state and beat outputs
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        done_nxt   = 1'b0;
        capture    = 1'b0;
        beat       = 1'b0;
        o_rdy      = 1'b0;
        o_vld      = 1'b0;
        o_lane_vld = '0;
        o_data     = '0;
        o_chunk    = '0;
        o_last     = 1'b0;
        case (state)
            IDLE: begin
                o_rdy = 1'b1;
                if (i_vld) begin
                    capture   = 1'b1;
                    ptr_nxt   = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                beat       = |mask;
                o_vld      = beat;
                o_lane_vld = mask;
                o_chunk    = ptr;
                o_last     = beat && !later_any;
                for (int j = 0; j < OUT_BW; j++) begin
                    o_data[j*DATA_TYPE +: DATA_TYPE] =
                        mask[j] ? chunk_data[j*DATA_TYPE +: DATA_TYPE] : '0;
                end
                // Empty chunks advance unconditionally as one-cycle bubbles
                if ((beat && i_rdy) || !beat) begin
                    ptr_nxt = ptr + LOG2_PES'(1);
                    if (ptr == LAST_CHUNK) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_done = done_q;

endmodule

// File: tb/tb_xbar_collect.sv
// Directed bench for xbar_collect: reset, full drain, sparse chunks, empty batch,
// backpressure and back-to-back batches.
module tb_xbar_collect;

    logic          clk = 1'b0;
    logic          rst;
    logic [1023:0] i_data_bus;
    logic [63:0]   i_valid_bus;
    logic          i_vld;
    logic          o_rdy;
    logic [255:0]  o_data;
    logic [15:0]   o_lane_vld;
    logic [5:0]    o_chunk;
    logic          o_vld;
    logic          i_rdy;
    logic          o_last;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    xbar_collect dut (
        .clk        (clk),
        .rst        (rst),
        .i_data_bus (i_data_bus),
        .i_valid_bus(i_valid_bus),
        .i_vld      (i_vld),
        .o_rdy      (o_rdy),
        .o_data     (o_data),
        .o_lane_vld (o_lane_vld),
        .o_chunk    (o_chunk),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_last     (o_last),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic vld, input logic [5:0] chunk,
                            input logic [15:0] lv, input logic [255:0] data, input logic last);
        chk({tag, ".vld"},   256'(o_vld),      256'(vld));
        chk({tag, ".chunk"}, 256'(o_chunk),    256'(chunk));
        chk({tag, ".lvld"},  256'(o_lane_vld), 256'(lv));
        chk({tag, ".data"},  o_data,           data);
        chk({tag, ".last"},  256'(o_last),     256'(last));
        chk({tag, ".done"},  256'(o_done),     256'(0));
        chk({tag, ".rdy"},   256'(o_rdy),      256'(0));
    endtask

    // Slot i carries base+i; all slots of chunk k are valid
    function automatic logic [255:0] full_chunk(input int base, input int k);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 16; j++) v[j*16 +: 16] = 16'(base + 16*k + j);
        return v;
    endfunction

    task automatic fill(input int base);
        for (int i = 0; i < 64; i++) i_data_bus[i*16 +: 16] = 16'(base + i);
    endtask

    logic [255:0] exp_d;
    logic [255:0] hold_d;

    initial begin
        rst = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
        i_data_bus = '0; i_valid_bus = '0;
        #12;
        chk("rst.rdy",   256'(o_rdy),      256'(1));
        chk("rst.vld",   256'(o_vld),      256'(0));
        chk("rst.last",  256'(o_last),     256'(0));
        chk("rst.done",  256'(o_done),     256'(0));
        chk("rst.data",  o_data,           256'(0));
        chk("rst.chunk", 256'(o_chunk),    256'(0));
        chk("rst.lvld",  256'(o_lane_vld), 256'(0));
        tick();
        rst = 1'b1;

        // Reset in the middle of a drain
        fill(0); i_valid_bus = '1; i_vld = 1'b1;
        tick(); i_vld = 1'b0;
        tick(); tick();
        chk_beat("mid.ptr2", 1'b1, 6'd2, 16'hFFFF, full_chunk(0, 2), 1'b0);
        rst = 1'b0;
        #1;
        chk("mid.vld", 256'(o_vld), 256'(0));
        chk("mid.rdy", 256'(o_rdy), 256'(1));
        tick(); rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("mid.nodone", 256'(o_done), 256'(0));
            tick();
        end

        // Full batch, slot i = i
        fill(0); i_valid_bus = '1; i_vld = 1'b1;
        chk("full.rdy_idle", 256'(o_rdy), 256'(1));
        tick(); i_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat("full.beat", 1'b1, 6'(k), 16'hFFFF, full_chunk(0, k), k == 3);
            tick();
        end
        chk("full.done", 256'(o_done), 256'(1));
        chk("full.rdy",  256'(o_rdy),  256'(1));
        chk("full.vld",  256'(o_vld),  256'(0));
        tick();
        chk("full.done_pulse", 256'(o_done), 256'(0));

        // Only slots 5 and 50 valid
        fill(16'hA000); i_valid_bus = (64'd1 << 5) | (64'd1 << 50); i_vld = 1'b1;
        tick(); i_vld = 1'b0;
        exp_d = '0; exp_d[5*16 +: 16] = 16'hA005;
        chk_beat("sp.c0", 1'b1, 6'd0, 16'h0020, exp_d, 1'b0);
        tick();
        chk_beat("sp.c1", 1'b0, 6'd1, 16'h0000, 256'(0), 1'b0);
        tick();
        chk_beat("sp.c2", 1'b0, 6'd2, 16'h0000, 256'(0), 1'b0);
        tick();
        exp_d = '0; exp_d[2*16 +: 16] = 16'hA032;
        chk_beat("sp.c3", 1'b1, 6'd3, 16'h0004, exp_d, 1'b1);
        tick();
        chk("sp.done", 256'(o_done), 256'(1));
        tick();

        // All-zero valid: four bubbles then done
        fill(16'h1234); i_valid_bus = '0; i_vld = 1'b1;
        tick(); i_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("zero.vld",  256'(o_vld),  256'(0));
            chk("zero.done", 256'(o_done), 256'(0));
            tick();
        end
        chk("zero.done_end", 256'(o_done), 256'(1));
        chk("zero.rdy_end",  256'(o_rdy),  256'(1));
        tick();

        // Backpressure on beat 1; chunks 2..3 empty so beat 1 is last
        fill(16'h4000); i_valid_bus = 64'h0000_0000_FFFF_FFFF; i_vld = 1'b1;
        tick(); i_vld = 1'b0;
        chk_beat("bp.c0", 1'b1, 6'd0, 16'hFFFF, full_chunk(16'h4000, 0), 1'b0);
        tick();
        i_rdy = 1'b0; i_vld = 1'b1; fill(16'h7700); i_valid_bus = '1;
        hold_d = full_chunk(16'h4000, 1);
        for (int c = 0; c < 5; c++) begin
            chk_beat("bp.hold", 1'b1, 6'd1, 16'hFFFF, hold_d, 1'b1);
            tick();
        end
        i_rdy = 1'b1; i_vld = 1'b0;
        chk_beat("bp.resume", 1'b1, 6'd1, 16'hFFFF, hold_d, 1'b1);
        tick();
        chk_beat("bp.b2", 1'b0, 6'd2, 16'h0000, 256'(0), 1'b0);
        tick();
        chk_beat("bp.b3", 1'b0, 6'd3, 16'h0000, 256'(0), 1'b0);
        tick();
        chk("bp.done", 256'(o_done), 256'(1));
        tick();

        // Back-to-back batches with i_vld held high
        fill(16'h0100); i_valid_bus = '1; i_vld = 1'b1;
        tick();
        fill(16'h0200);
        for (int k = 0; k < 4; k++) begin
            chk_beat("b2b.a", 1'b1, 6'(k), 16'hFFFF, full_chunk(16'h0100, k), k == 3);
            tick();
        end
        chk("b2b.done_a", 256'(o_done), 256'(1));
        chk("b2b.rdy_a",  256'(o_rdy),  256'(1));
        tick();
        i_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_beat("b2b.b", 1'b1, 6'(k), 16'hFFFF, full_chunk(16'h0200, k), k == 3);
            tick();
        end
        chk("b2b.done_b", 256'(o_done), 256'(1));
        tick();
        chk("b2b.idle_vld", 256'(o_vld), 256'(0));
        chk("b2b.idle_rdy", 256'(o_rdy), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
